// File: rtl/dcache_direct_if.sv
// rtl/dcache_direct_if.sv - CPU request and memory line-port bundle for dcache_direct
interface dcache_direct_if #(
    parameter int ADDR_W = 32
);
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_wdata;
    logic [31:0]       proc_rdata;
    logic              proc_stall;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-5:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_direct.sv
// rtl/dcache_direct.sv - direct-mapped write-back write-allocate data cache, 4-word lines
// Optional hit/miss counters enabled by defining DCACHE_STATS_EN.
module dcache_direct #(
    parameter int LINE_CNT = 8,
    parameter int ADDR_W   = 32
) (
    input  logic           clk,
    input  logic           rst,
    dcache_direct_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]    hit_cnt,
    output logic [15:0]    miss_cnt
`endif
);
    localparam int IDX_W = $clog2(LINE_CNT);
    localparam int TAG_W = ADDR_W - 4 - IDX_W;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;

    logic [1:0]          r_state;
    logic [LINE_CNT-1:0] r_valid;
    logic [LINE_CNT-1:0] r_dirty;
    logic [TAG_W-1:0]    r_tag  [LINE_CNT];
    logic [127:0]        r_data [LINE_CNT];

    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-5:0]   r_mem_addr;
    logic [127:0]        r_mem_wdata;

    logic [1:0]          w_word;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_req;
    logic                w_wr;
    logic                w_idle;
    logic                w_hit;
    logic [127:0]        w_line;
    logic [31:0]         w_word_data;
    logic                w_unused;

    assign w_word      = bus.proc_addr[3:2];
    assign w_idx       = bus.proc_addr[4 +: IDX_W];
    assign w_tag       = bus.proc_addr[ADDR_W-1 -: TAG_W];
    assign w_req       = bus.proc_read | bus.proc_write;
    assign w_wr        = bus.proc_write;
    assign w_idle      = (r_state == S_IDLE);
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line      = r_data[w_idx];
    assign w_word_data = w_line[{w_word, 5'd0} +: 32];
    assign w_unused    = &{1'b0, bus.proc_addr[1:0]};

    // Gating with rst makes the CPU-side outputs fall to their reset values the moment rst drops.
    assign bus.proc_stall = rst && (w_idle ? (w_req && !w_hit) : 1'b1);
    assign bus.proc_rdata = (rst && w_idle && bus.proc_read && !w_wr && w_hit) ? w_word_data : 32'd0;

    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (w_wr) r_dirty[w_idx] <= 1'b1;
                        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state     <= S_WRITEBACK;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {r_tag[w_idx], w_idx};
                            r_mem_wdata <= w_line;
                        end else begin
                            r_state    <= S_ALLOCATE;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= bus.proc_addr[ADDR_W-1:4];
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (bus.mem_ready) begin
                        r_state     <= S_ALLOCATE;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_mem_addr  <= bus.proc_addr[ADDR_W-1:4];
                    end
                end
                S_ALLOCATE: begin
                    if (bus.mem_ready) begin
                        r_state        <= S_IDLE;
                        r_mem_read     <= 1'b0;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line storage is not reset; the valid bits alone decide whether its contents matter.
    always_ff @(posedge clk) begin
        if (w_idle && w_req && w_hit && w_wr) begin
            r_data[w_idx][{w_word, 5'd0} +: 32] <= bus.proc_wdata;
        end else if ((r_state == S_ALLOCATE) && bus.mem_ready) begin
            r_data[w_idx] <= bus.mem_rdata;
            r_tag[w_idx]  <= w_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        r_missed;
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // r_missed remembers that the pending access left IDLE, so its final hit is booked as a miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_missed   <= 1'b0;
            r_hit_cnt  <= 16'd0;
            r_miss_cnt <= 16'd0;
        end else if (w_idle && w_req) begin
            if (w_hit) begin
                if (r_missed) begin
                    r_missed <= 1'b0;
                    if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
                end else if (r_hit_cnt != 16'hFFFF) begin
                    r_hit_cnt <= r_hit_cnt + 16'd1;
                end
            end else begin
                r_missed <= 1'b1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif
endmodule

// File: tb/tb_dcache_direct.sv
// tb/tb_dcache_direct.sv - directed and randomized checks of dcache_direct against a memory/cache model
module tb_dcache_direct;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dcache_direct_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    dcache_direct #(.LINE_CNT(8), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Slow memory contents per line address, and the architecturally expected value per word address.
    logic [127:0] backing [logic [27:0]];
    logic [31:0]  refw    [logic [29:0]];

    // Which memory line each cache index should currently hold.
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [27:0]  m_line  [8];

    // Observations from the most recent access.
    logic [31:0]  a_rdata;
    int           a_stall, a_nev, a_nrf, a_first;
    bit           a_moved, a_both, a_done;
    logic [27:0]  a_ev_addr, a_rf_addr;
    logic [127:0] a_ev_data;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [29:0] wa);
        return {wa[15:0] ^ 16'h5A3C, ~wa[15:0]};
    endfunction

    function automatic logic [127:0] line_of(input logic [27:0] la);
        if (backing.exists(la)) return backing[la];
        return {pat({la, 2'd3}), pat({la, 2'd2}), pat({la, 2'd1}), pat({la, 2'd0})};
    endfunction

    function automatic logic [31:0] ref_word(input logic [29:0] wa);
        if (refw.exists(wa)) return refw[wa];
        return pat(wa);
    endfunction

    // Dirty data that never reached memory is lost by a reset.
    task automatic reset_model();
        logic [127:0] l;
        for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && m_dirty[i]) begin
                l = line_of(m_line[i]);
                for (int w = 0; w < 4; w++) refw[{m_line[i], w[1:0]}] = l[w*32 +: 32];
            end
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int lat);
        int          wait_cnt;
        logic [27:0] cur;
        wait_cnt = 0; cur = '0;
        a_rdata = '0; a_stall = 0; a_nev = 0; a_nrf = 0; a_first = -1;
        a_moved = 0; a_both = 0; a_done = 0;
        @(negedge clk);
        bus.proc_read = rd; bus.proc_write = wr; bus.proc_addr = addr; bus.proc_wdata = wd;
        #1;
        for (int c = 0; c < 200; c++) begin
            if (!bus.proc_stall) begin
                a_rdata = bus.proc_rdata;
                a_done  = 1;
                break;
            end
            a_stall++;
            if (bus.mem_read && bus.mem_write) a_both = 1;
            if (bus.mem_read || bus.mem_write) begin
                if (wait_cnt == 0) begin
                    cur = bus.mem_addr;
                    if (bus.mem_write) begin
                        a_nev++; a_ev_addr = bus.mem_addr; a_ev_data = bus.mem_wdata;
                        if (a_first < 0) a_first = 1;
                    end else begin
                        a_nrf++; a_rf_addr = bus.mem_addr;
                        if (a_first < 0) a_first = 0;
                    end
                end else if (bus.mem_addr !== cur) begin
                    a_moved = 1;
                end
                if (wait_cnt == lat) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_write) backing[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = line_of(bus.mem_addr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
        end
    endtask

    task automatic verify(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int lat);
        logic [2:0]   idx;
        logic [27:0]  la, ev_la;
        logic [29:0]  wa;
        bit           hit, ev;
        logic [127:0] exp_ev;
        int           exp_stall;
        idx = addr[6:4]; la = addr[31:4]; wa = addr[31:2];
        hit = m_valid[idx] && (m_line[idx] == la);
        ev  = !hit && m_valid[idx] && m_dirty[idx];
        ev_la  = m_line[idx];
        exp_ev = {ref_word({ev_la, 2'd3}), ref_word({ev_la, 2'd2}),
                  ref_word({ev_la, 2'd1}), ref_word({ev_la, 2'd0})};
        // One cycle to detect the miss, then each memory request is up for lat+1 cycles.
        exp_stall = hit ? 0 : (ev ? 2 * (lat + 1) + 1 : lat + 2);
        access(rd, wr, addr, wd, lat);
        check("done", a_done, 1'b1);
        check("stall_cycles", a_stall, exp_stall);
        check("evict_count", a_nev, ev);
        check("refill_count", a_nrf, !hit);
        check("no_dual_req", a_both, 1'b0);
        check("mem_addr_held", a_moved, 1'b0);
        if (ev) begin
            check("evict_addr", a_ev_addr, ev_la);
            check("evict_data", a_ev_data, exp_ev);
            check("evict_first", a_first, 1);
        end
        if (!hit) check("refill_addr", a_rf_addr, la);
        if (rd && !wr) check("rdata", a_rdata, ref_word(wa));
        if (wr) refw[wa] = wd;
        m_dirty[idx] = hit ? (m_dirty[idx] | wr) : wr;
        m_valid[idx] = 1'b1;
        m_line[idx]  = la;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        bit          rd, wr;
        bus.proc_read = 0; bus.proc_write = 0; bus.proc_addr = '0; bus.proc_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 0;
        for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_line[i] = '0; end

        // Reset state, with a pending read that would otherwise miss.
        bus.proc_read = 1; bus.proc_addr = 32'h40;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", bus.proc_stall, 1'b0);
        check("rst_rdata", bus.proc_rdata, 32'd0);
        check("rst_mem_read", bus.mem_read, 1'b0);
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 28'd0);
        check("rst_mem_wdata", bus.mem_wdata, 128'd0);
        @(negedge clk);
        bus.proc_read = 0;
        rst = 1;

        // T1 cold read miss on a preloaded line {D,C,B,A}
        backing[28'h4] = {32'hDDDD_000D, 32'hCCCC_000C, 32'hBBBB_000B, 32'hAAAA_000A};
        refw[30'h10] = 32'hAAAA_000A; refw[30'h11] = 32'hBBBB_000B;
        refw[30'h12] = 32'hCCCC_000C; refw[30'h13] = 32'hDDDD_000D;
        verify(1, 0, 32'h40, 32'h0, 3);
        check("t1_rdata_A", a_rdata, 32'hAAAA_000A);
        check("t1_refill_addr", a_rf_addr, 28'h4);

        // T2 read hit
        verify(1, 0, 32'h48, 32'h0, 3);
        check("t2_rdata_C", a_rdata, 32'hCCCC_000C);
        check("t2_no_refill", a_nrf, 0);

        // T3 write hit then conflicting read forcing a dirty eviction
        verify(0, 1, 32'h44, 32'hDEADBEEF, 3);
        check("t3_write_no_stall", a_stall, 0);
        verify(1, 0, 32'hC0, 32'h0, 3);
        check("t3_evict_addr", a_ev_addr, 28'h4);
        check("t3_evict_word1", a_ev_data[63:32], 32'hDEADBEEF);
        check("t3_refill_addr", a_rf_addr, 28'hC);
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        check("t6_hit_cnt", hit_cnt, 16'd2);
        check("t6_miss_cnt", miss_cnt, 16'd2);
`endif

        // T4 slow memory
        verify(1, 0, 32'h1000, 32'h0, 20);
        check("t4_one_refill", a_nrf, 1);
        check("t4_stall_len", a_stall, 22);

        // T5 reset in the middle of a refill
        @(negedge clk);
        bus.proc_read = 1; bus.proc_write = 0; bus.proc_addr = 32'h40;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.mem_read) break;
        end
        check("t5_refill_started", bus.mem_read, 1'b1);
        @(negedge clk);
        rst = 0;
        #1;
        check("t5_mem_read_drop", bus.mem_read, 1'b0);
        check("t5_stall_drop", bus.proc_stall, 1'b0);
        check("t5_mem_addr_clr", bus.mem_addr, 28'd0);
        reset_model();
        @(negedge clk);
        bus.proc_read = 0;
        rst = 1;
        verify(1, 0, 32'h40, 32'h0, 2);
        check("t5_miss_again", a_nrf, 1);

        // Randomized traffic over 32 lines sharing 8 indices
        for (int n = 0; n < 150; n++) begin
            addr = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            rd = $urandom_range(0, 1);
            wr = !rd || ($urandom_range(0, 7) == 0);
            verify(rd, wr, addr, $urandom, $urandom_range(0, 4));
        end

`ifdef DCACHE_STATS_EN
        verify(1, 0, 32'h48, 32'h0, 1);
        repeat (65540) @(negedge clk);
        check("t6_hit_saturate", hit_cnt, 16'hFFFF);
`endif

        @(negedge clk);
        bus.proc_read = 0; bus.proc_write = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
